// File: rtl/pipe_hazard_ctl.sv
`timescale 1ns/1ps
// pipe_hazard_ctl
//   Hazard and forwarding controller for the five-stage pipeline
//   (IF/ID/EX/MEM/WB). It keeps a private shadow of the ID/EX, EX/MEM and
//   MEM/WB registers. From that shadow it decodes the load-use stall, the EX
//   operand-forwarding selects and the flush of younger stages on a taken
//   branch.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   id_valid .. id_memread  decoded fields of the instruction held in ID
//   br_taken                branch in MEM resolved taken this cycle
//   stall                   hold PC and IF/ID, bubble into ID/EX
//   flush_ifid/idex/exmem   clear the younger pipeline registers
//   fwd_a, fwd_b            EX operand select: 00 regfile, 01 WB, 10 MEM
//   stall_cnt, flush_cnt    saturating performance counters
//
// Build option
//   PIPE_HAZARD_PERF_CNT_EN  when defined, stall_cnt/flush_cnt count stall
//                            cycles and taken-branch flushes. When undefined
//                            both outputs are tied to zero and no counter
//                            flops exist.
//
// Shadow slots: _p0 = EX (ID/EX), _p1 = MEM (EX/MEM), _p2 = WB (MEM/WB).
// Only the valid bits and counters are reset; the remaining fields are
// ignored whenever the matching valid bit is low.

module pipe_hazard_ctl #(
    parameter int NREG_BITS = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NREG_BITS-1:0] id_rs,
    input  logic [NREG_BITS-1:0] id_rt,
    input  logic                 id_uses_rt,
    input  logic [NREG_BITS-1:0] id_wrreg,
    input  logic                 id_regwrite,
    input  logic                 id_memread,
    input  logic                 br_taken,
    output logic                 stall,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 flush_exmem,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    logic                 vld_p0, vld_p1, vld_p2;
    logic [NREG_BITS-1:0] rs_p0, rt_p0;
    logic [NREG_BITS-1:0] wrreg_p0, wrreg_p1, wrreg_p2;
    logic                 regwrite_p0, regwrite_p1, regwrite_p2;
    logic                 memread_p0, memread_p1;

    logic ex_writer, mem_writer, wb_writer;

    // Operand select for one EX source. MEM wins over WB because it holds the
    // younger result; a load still in MEM has no data yet, so it never
    // forwards from MEM.
    function automatic logic [1:0] fwd_sel(
        input logic [NREG_BITS-1:0] src,
        input logic                 mem_wr,
        input logic                 mem_is_load,
        input logic [NREG_BITS-1:0] mem_reg,
        input logic                 wb_wr,
        input logic [NREG_BITS-1:0] wb_reg
    );
        if (mem_wr && !mem_is_load && (mem_reg == src))
            return 2'b10;
        else if (wb_wr && (wb_reg == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Writers exclude register 0, which removes every r0 stall and forward.
    assign ex_writer  = vld_p0 && regwrite_p0 && (wrreg_p0 != '0);
    assign mem_writer = vld_p1 && regwrite_p1 && (wrreg_p1 != '0);
    assign wb_writer  = vld_p2 && regwrite_p2 && (wrreg_p2 != '0);

    assign stall = id_valid && !br_taken && memread_p0 && ex_writer &&
                   ((wrreg_p0 == id_rs) || (id_uses_rt && (wrreg_p0 == id_rt)));

    assign flush_ifid  = br_taken;
    assign flush_idex  = br_taken;
    assign flush_exmem = br_taken;

    // A bubble in EX has meaningless source fields, so it selects nothing.
    assign fwd_a = vld_p0 ? fwd_sel(rs_p0, mem_writer, memread_p1, wrreg_p1,
                                    wb_writer, wrreg_p2) : 2'b00;
    assign fwd_b = vld_p0 ? fwd_sel(rt_p0, mem_writer, memread_p1, wrreg_p1,
                                    wb_writer, wrreg_p2) : 2'b00;

    // ID -> EX (_p0) -> MEM (_p1) -> WB (_p2), valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= id_valid && !stall && !br_taken;
            vld_p1 <= vld_p0 && !br_taken;
            vld_p2 <= vld_p1;
        end
    end

    // ID -> EX (_p0) -> MEM (_p1) -> WB (_p2), payload fields
    always_ff @(posedge clk) begin
        rs_p0       <= id_rs;
        rt_p0       <= id_rt;
        wrreg_p0    <= id_wrreg;
        regwrite_p0 <= id_regwrite;
        memread_p0  <= id_memread;
        wrreg_p1    <= wrreg_p0;
        regwrite_p1 <= regwrite_p0;
        memread_p1  <= memread_p0;
        wrreg_p2    <= wrreg_p1;
        regwrite_p2 <= regwrite_p1;
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (br_taken)
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
`timescale 1ns/1ps
// Testbench for pipe_hazard_ctl: a directed vector table streamed one ID
// instruction per cycle, followed by hand-written reset and counter
// saturation sequences. A second instance with CNT_W=2 shares the stimulus.

module tb_pipe_hazard_ctl;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_wrreg;
    logic       id_uses_rt, id_regwrite, id_memread;
    logic       br_taken;

    logic        stall, flush_ifid, flush_idex, flush_exmem;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall, s_flush_ifid, s_flush_idex, s_flush_exmem;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctl #(.NREG_BITS(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_wrreg(id_wrreg),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .br_taken(br_taken), .stall(stall), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctl #(.NREG_BITS(5), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_wrreg(id_wrreg),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .br_taken(br_taken), .stall(s_stall), .flush_ifid(s_flush_ifid),
        .flush_idex(s_flush_idex), .flush_exmem(s_flush_exmem),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       ut;
        logic [4:0] wr;
        logic       rw, mr, br;
        logic       e_stall;
        logic [1:0] e_fa, e_fb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input int rs, input int rt,
                                input logic ut, input int wr, input logic rw,
                                input logic mr, input logic br, input logic st,
                                input logic [1:0] fa, input logic [1:0] fb);
        vec_t r;
        r.v = v;   r.rs = rs[4:0]; r.rt = rt[4:0]; r.ut = ut;
        r.wr = wr[4:0]; r.rw = rw; r.mr = mr; r.br = br;
        r.e_stall = st; r.e_fa = fa; r.e_fb = fb;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid    = v.v;
        id_rs       = v.rs;
        id_rt       = v.rt;
        id_uses_rt  = v.ut;
        id_wrreg    = v.wr;
        id_regwrite = v.rw;
        id_memread  = v.mr;
        br_taken    = v.br;
    endtask

    // Advance one cycle: new ID contents just after the edge, outputs
    // sampled on the falling edge.
    task automatic step(input vec_t v);
        @(posedge clk);
        #1 drive(v);
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        id_valid    = 1'($urandom);
        id_rs       = 5'($urandom);
        id_rt       = 5'($urandom);
        id_uses_rt  = 1'($urandom);
        id_wrreg    = 5'($urandom);
        id_regwrite = 1'($urandom);
        id_memread  = 1'($urandom);
        br_taken    = 1'($urandom);
    endtask

    vec_t nop, lw5, add6;

    initial begin
        nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        lw5  = mk(1, 2, 5, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00);  // lw  $5,0($2)
        add6 = mk(1, 5, 2, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00);  // add $6,$5,$2

        //              v rs rt ut wr rw mr br st fwd_a  fwd_b
        tbl.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00)); //  0 add $3,$1,$2
        tbl.push_back(mk(1, 3, 3, 1, 4, 1, 0, 0, 0, 2'b00, 2'b00)); //  1 sub $4,$3,$3
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10)); //  2 sub in EX, add in MEM
        tbl.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00)); //  3 add $3,$1,$2
        tbl.push_back(mk(1, 8, 9, 1, 7, 1, 0, 0, 0, 2'b00, 2'b00)); //  4 or  $7,$8,$9
        tbl.push_back(mk(1, 3, 3, 1, 4, 1, 0, 0, 0, 2'b00, 2'b00)); //  5 sub $4,$3,$3
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01)); //  6 add now in WB
        tbl.push_back(mk(1, 2, 5, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00)); //  7 lw  $5,0($2)
        tbl.push_back(mk(1, 5, 2, 1, 6, 1, 0, 0, 1, 2'b00, 2'b00)); //  8 add $6,$5,$2 stalls
        tbl.push_back(mk(1, 5, 2, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00)); //  9 held, bubble in EX
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00)); // 10 add in EX, lw in WB
        tbl.push_back(mk(1, 2, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00)); // 11 lw  $0,0($2)
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00)); // 12 add $1,$0,$0
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)); // 13 r0 never forwards
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)); // 14
        tbl.push_back(mk(1, 2, 5, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00)); // 15 lw  $5,0($2)
        tbl.push_back(mk(1, 4, 5, 0, 9, 1, 0, 0, 0, 2'b00, 2'b00)); // 16 rt=5 but unused
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)); // 17 load in MEM: no fwd
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)); // 18
        tbl.push_back(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00)); // 19 add $3,$1,$2
        tbl.push_back(mk(1, 8, 9, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00)); // 20 or  $3,$8,$9
        tbl.push_back(mk(1, 3, 1, 1, 4, 1, 0, 0, 0, 2'b00, 2'b00)); // 21 sub $4,$3,$1
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00)); // 22 MEM beats WB
        tbl.push_back(mk(1, 2, 5, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00)); // 23 lw  $5,0($2)
        tbl.push_back(mk(1, 5, 2, 1, 6, 1, 0, 1, 0, 2'b00, 2'b00)); // 24 load-use + taken br
        tbl.push_back(mk(1, 5, 2, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00)); // 25 lw gone: no stall
        tbl.push_back(mk(1, 5, 6, 1, 7, 1, 0, 0, 0, 2'b00, 2'b00)); // 26 sub $7,$5,$6
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10)); // 27 fwd only from add

        // Start from reset with a quiet ID stage.
        reset = 1'b1;
        drive(nop);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i]);
            check($sformatf("vec%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
            check($sformatf("vec%0d flush", i),
                  32'({flush_ifid, flush_idex, flush_exmem}),
                  32'({3{tbl[i].br}}));
            check($sformatf("vec%0d fwd_a", i), 32'(fwd_a), 32'(tbl[i].e_fa));
            check($sformatf("vec%0d fwd_b", i), 32'(fwd_b), 32'(tbl[i].e_fb));
        end

        // One stall cycle and one flush so far.
        step(nop);
        check("tbl stall_cnt", 32'(stall_cnt), PERF ? 32'd1 : 32'd0);
        check("tbl flush_cnt", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
        check("tbl sat flush_cnt", 32'(s_flush_cnt), PERF ? 32'd1 : 32'd0);

        // Reset lands while a load-use stall is active, then random inputs.
        step(nop);
        step(lw5);
        step(add6);
        check("pre-reset stall", 32'(stall), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 randomize_inputs();
        @(posedge clk);
        #1 randomize_inputs();
        reset    = 1'b0;
        br_taken = 1'b0;
        @(negedge clk);
        check("reset stall", 32'(stall), 32'd0);
        check("reset flush", 32'({flush_ifid, flush_idex, flush_exmem}), 32'd0);
        check("reset fwd_a", 32'(fwd_a), 32'd0);
        check("reset fwd_b", 32'(fwd_b), 32'd0);
        check("reset stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset flush_cnt", 32'(flush_cnt), 32'd0);
        check("reset sat stall_cnt", 32'(s_stall_cnt), 32'd0);

        // Drain whatever random instruction entered EX.
        step(nop);
        step(nop);

        // Five load-use pairs: one stall each; the 2-bit counter sticks at 3.
        for (int p = 0; p < 5; p++) begin
            step(lw5);
            check($sformatf("pair%0d lw stall", p), 32'(stall), 32'd0);
            step(add6);
            check($sformatf("pair%0d use stall", p), 32'(stall), 32'd1);
            step(add6);
            check($sformatf("pair%0d held stall", p), 32'(stall), 32'd0);
            if (p == 2)
                check("sat stall_cnt at 3", 32'(s_stall_cnt), PERF ? 32'd3 : 32'd0);
        end
        step(nop);
        check("stall_cnt after 5", 32'(stall_cnt), PERF ? 32'd5 : 32'd0);
        check("sat stall_cnt after 5", 32'(s_stall_cnt), PERF ? 32'd3 : 32'd0);
        check("flush_cnt after 5", 32'(flush_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
